fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch with a one-entry skid buffer and flush redirect.
//            Optional perf counters are enabled by defining FETCH_PERF_EN.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] flush_pc,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic [15:0] instruction,
  output logic [15:0] inst_pc,
  output logic        inst_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_stalls
`endif
);

  logic [15:0] pc_q, pc_d;
  logic        req_pending_q, req_pending_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_data_q, skid_data_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic [15:0] instruction_q, instruction_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;

  assign mem_rd_en   = !reset && !flush && !stall;
  assign mem_addr    = pc_q;
  assign instruction = instruction_q;
  assign inst_pc     = inst_pc_q;
  assign inst_valid  = inst_valid_q;

  always_comb begin
    pc_d          = pc_q;
    req_pending_d = req_pending_q;
    req_addr_d    = req_addr_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_pc_d     = skid_pc_q;
    instruction_d = instruction_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;

    if (flush) begin
      pc_d          = flush_pc;
      req_pending_d = 1'b0;
      skid_valid_d  = 1'b0;
      inst_valid_d  = 1'b0;
      instruction_d = NOP_INST;
    end else if (stall) begin
      // Data returning for the last issued read is parked until stall drops.
      if (req_pending_q) begin
        skid_data_d   = mem_data;
        skid_pc_d     = req_addr_q;
        skid_valid_d  = 1'b1;
        req_pending_d = 1'b0;
      end
    end else begin
      if (skid_valid_q) begin
        instruction_d = skid_data_q;
        inst_pc_d     = skid_pc_q;
        inst_valid_d  = 1'b1;
        skid_valid_d  = 1'b0;
      end else if (req_pending_q) begin
        instruction_d = mem_data;
        inst_pc_d     = req_addr_q;
        inst_valid_d  = 1'b1;
      end else begin
        instruction_d = NOP_INST;
        inst_valid_d  = 1'b0;
      end
      req_pending_d = 1'b1;
      req_addr_d    = pc_q;
      pc_d          = pc_q + 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      req_pending_q <= 1'b0;
      req_addr_q    <= 16'h0000;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= 16'h0000;
      skid_pc_q     <= 16'h0000;
      instruction_q <= NOP_INST;
      inst_pc_q     <= 16'h0000;
      inst_valid_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      req_pending_q <= req_pending_d;
      req_addr_q    <= req_addr_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_pc_q     <= skid_pc_d;
      instruction_q <= instruction_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;

  assign perf_fetched = perf_fetched_q;
  assign perf_stalls  = perf_stalls_q;

  // Both counters saturate; flush does not clear them.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stalls_d  = perf_stalls_q;
    if (inst_valid_q && (perf_fetched_q != 16'hFFFF)) begin
      perf_fetched_d = perf_fetched_q + 16'h0001;
    end
    if (stall && !flush && (perf_stalls_q != 16'hFFFF)) begin
      perf_stalls_d = perf_stalls_q + 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= 16'h0000;
      perf_stalls_q  <= 16'h0000;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end
`endif

endmodule
`default_nettype wire
